// File: rtl/cic_comp_fir.sv
// Compensation/decimation FIR behind the CIC decimator.
// A single MAC walks a circular delay line, newest sample first, then rounds and saturates the result.
module cic_comp_fir #(
  parameter int IN_W = 31,
  parameter int OUT_W = 24,
  parameter int COEF_W = 16,
  parameter int TAPS = 16,
  parameter logic [TAPS*COEF_W-1:0] COEFS = {TAPS{COEF_W'(2048)}},
  parameter int DECIM = 2,
  parameter int SHIFT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  d_in,
  input  logic             d_clk,
  output logic [OUT_W-1:0] d_out,
  output logic             d_out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int ACC_W = IN_W + COEF_W + $clog2(TAPS);
  localparam int PTR_W = $clog2(TAPS);
  localparam int IDX_W = PTR_W + 1;
  localparam logic signed [ACC_W-1:0] RND =
    (SHIFT == 0) ? '0 : (ACC_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0));
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t state_reg, state_next;

  logic                     d_clk_q;
  logic signed [IN_W-1:0]   line [TAPS];
  logic [PTR_W-1:0]         wr_ptr_reg;
  logic                     phase_reg;
  logic [PTR_W-1:0]         k_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  r_reg;

  logic signed [COEF_W-1:0] coef_rom [TAPS];
  logic                     strobe;
  logic                     accept;
  logic                     phase_last;
  logic [IDX_W-1:0]         rd_sum;
  logic [PTR_W-1:0]         rd_idx;
  logic signed [IN_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]  rounded;

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
      assign coef_rom[gi] = COEFS[gi*COEF_W +: COEF_W];
    end
  endgenerate

  assign busy       = (state_reg == MAC) || (state_reg == ROUND);
  assign strobe     = d_clk & ~d_clk_q & en;
  assign accept     = strobe & ~busy;
  assign phase_last = (phase_reg == 1'(DECIM - 1));

  // Tap k reads x[n-k]; the newest sample sits just behind wr_ptr.
  always_comb begin
    rd_sum = IDX_W'(wr_ptr_reg) + IDX_W'(TAPS - 1) - IDX_W'(k_reg);
    rd_idx = PTR_W'(rd_sum);
    if (rd_sum >= IDX_W'(TAPS))
      rd_idx = PTR_W'(rd_sum - IDX_W'(TAPS));
  end

  assign prod    = line[rd_idx] * coef_rom[k_reg];
  assign rounded = (acc_reg + RND) >>> SHIFT;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, OUT: state_next = (accept && phase_last) ? MAC : IDLE;
      MAC:       if (k_reg == PTR_W'(TAPS - 1)) state_next = ROUND;
      ROUND:     state_next = OUT;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      d_clk_q     <= 1'b0;
      wr_ptr_reg  <= '0;
      phase_reg   <= 1'b0;
      k_reg       <= '0;
      acc_reg     <= '0;
      r_reg       <= '0;
      d_out       <= '0;
      d_out_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < TAPS; i++) line[i] <= '0;
    end else begin
      d_clk_q     <= d_clk;
      d_out_valid <= 1'b0;
      if (accept) begin
        line[wr_ptr_reg] <= $signed(d_in);
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(TAPS - 1)) ? '0 : wr_ptr_reg + 1'b1;
        phase_reg  <= phase_last ? 1'b0 : phase_reg + 1'b1;
      end
      if (strobe && busy) overrun <= 1'b1;
      case (state_reg)
        MAC: begin
          acc_reg <= acc_reg + ACC_W'(prod);
          k_reg   <= k_reg + 1'b1;
        end
        ROUND: r_reg <= rounded;
        OUT: begin
          if (r_reg > SAT_MAX)      d_out <= OUT_MAX;
          else if (r_reg < SAT_MIN) d_out <= OUT_MIN;
          else                      d_out <= r_reg[OUT_W-1:0];
          d_out_valid <= 1'b1;
          acc_reg     <= '0;
          k_reg       <= '0;
        end
        default: begin
          acc_reg <= '0;
          k_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: instance a (ramp coefs, SHIFT=0, DECIM=1),
// instance b (flat default coefs, SHIFT=15, DECIM=2).
module tb_cic_comp_fir;

  function automatic logic [255:0] ramp_coefs();
    logic [255:0] c;
    c = '0;
    for (int k = 0; k < 16; k++) c[k*16 +: 16] = 16'(k + 1);
    return c;
  endfunction

  localparam logic [255:0] COEFS_RAMP = ramp_coefs();

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;
  logic        d_clk = 1'b0;
  logic [30:0] d_in = '0;
  logic [23:0] dout_a, dout_b;
  logic        valid_a, valid_b, busy_a, busy_b, ovr_a, ovr_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [23:0] qa_val[$];
  logic [23:0] qb_val[$];
  int qa_cyc[$];
  int qb_cyc[$];
  int sa[$];

  cic_comp_fir #(.TAPS(16), .COEFS(COEFS_RAMP), .DECIM(1), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .d_in(d_in), .d_clk(d_clk),
    .d_out(dout_a), .d_out_valid(valid_a), .busy(busy_a), .overrun(ovr_a)
  );

  cic_comp_fir #(.DECIM(2), .SHIFT(15)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .d_in(d_in), .d_clk(d_clk),
    .d_out(dout_b), .d_out_valid(valid_b), .busy(busy_b), .overrun(ovr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a) begin qa_val.push_back(dout_a); qa_cyc.push_back(cyc); end
    if (valid_b) begin qb_val.push_back(dout_b); qb_cyc.push_back(cyc); end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_queues();
    qa_val.delete(); qa_cyc.delete(); qb_val.delete(); qb_cyc.delete(); sa.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; d_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_queues();
  endtask

  // d_clk is held high for two cycles: must still yield a single strobe.
  task automatic send(input int v, input int spacing);
    @(negedge clk);
    d_in = 31'(v); d_clk = 1'b1; sa.push_back(cyc);
    repeat (2) @(negedge clk);
    d_clk = 1'b0;
    repeat (spacing - 3) @(negedge clk);
  endtask

  task automatic test_reset();
    en_a = 1'b0; en_b = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (dout_a !== 24'd0) begin fails++; $display("FAIL reset_dout_a: got %0d want 0", dout_a); end
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    tests++; if (ovr_a !== 1'b0) begin fails++; $display("FAIL reset_overrun_a: got %b want 0", ovr_a); end
    tests++; if (dout_b !== 24'd0) begin fails++; $display("FAIL reset_dout_b: got %0d want 0", dout_b); end
    tests++; if ({valid_b, busy_b, ovr_b} !== 3'b000) begin fails++; $display("FAIL reset_flags_b: got %b want 000", {valid_b, busy_b, ovr_b}); end
    rst = 1'b1;
    clear_queues();
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_enable();
    en_a = 1'b0;
    send(5000, 24);
    repeat (25) @(negedge clk);
    tests++; if (qa_val.size() != 0) begin fails++; $display("FAIL enable_no_output: got %0d outputs want 0", qa_val.size()); end
    tests++; if (ovr_a !== 1'b0) begin fails++; $display("FAIL enable_no_overrun: got %b want 0", ovr_a); end
    $display("[TB] enable: strobe with en=0 ignored");
  endtask

  task automatic test_impulse();
    int exp;
    clear_queues();
    en_a = 1'b1;
    send(1000, 24);
    repeat (19) send(0, 24);
    repeat (25) @(negedge clk);
    tests++; if (qa_val.size() != 20) begin fails++; $display("FAIL impulse_count: got %0d want 20", qa_val.size()); end
    for (int j = 0; j < 20 && j < qa_val.size(); j++) begin
      exp = (j < 16) ? 1000 * (j + 1) : 0;
      tests++;
      if (qa_val[j] !== 24'(exp)) begin fails++; $display("FAIL impulse_out%0d: got %0d want %0d", j, $signed(qa_val[j]), exp); end
      tests++;
      if (qa_cyc[j] != sa[j] + 19) begin fails++; $display("FAIL impulse_latency%0d: got %0d want %0d", j, qa_cyc[j] - sa[j], 19); end
      $display("[TB] impulse out %0d: d_out=%0d", j, $signed(qa_val[j]));
    end
    en_a = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    en_a = 1'b1;
    repeat (16) send(1073741823, 24);
    repeat (16) send(-1073741824, 24);
    repeat (25) @(negedge clk);
    tests++; if (qa_val.size() != 32) begin fails++; $display("FAIL sat_count: got %0d want 32", qa_val.size()); end
    if (qa_val.size() == 32) begin
      tests++; if (qa_val[0] !== 24'h7FFFFF) begin fails++; $display("FAIL sat_pos_first: got %0d want 8388607", $signed(qa_val[0])); end
      tests++; if (qa_val[15] !== 24'h7FFFFF) begin fails++; $display("FAIL sat_pos: got %0d want 8388607", $signed(qa_val[15])); end
      tests++; if (qa_val[16] !== 24'h7FFFFF) begin fails++; $display("FAIL sat_mixed: got %0d want 8388607", $signed(qa_val[16])); end
      tests++; if (qa_val[31] !== 24'h800000) begin fails++; $display("FAIL sat_neg: got %0d want -8388608", $signed(qa_val[31])); end
      $display("[TB] saturation: pos=%0d neg=%0d", $signed(qa_val[15]), $signed(qa_val[31]));
    end
    en_a = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    en_a = 1'b1;
    send(5, 8);
    send(7, 8);
    tests++; if (ovr_a !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b want 1", ovr_a); end
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL overrun_busy: got %b want 1", busy_a); end
    send(9, 24);
    repeat (5) @(negedge clk);
    tests++; if (qa_val.size() != 1 || qa_val[0] !== 24'd5) begin fails++; $display("FAIL overrun_first_out: got n=%0d want one output of 5", qa_val.size()); end
    send(100, 24);
    repeat (5) @(negedge clk);
    // 100*c0 + 5*c1: the dropped 7 and 9 never entered the line
    tests++; if (qa_val.size() != 2 || qa_val[qa_val.size()-1] !== 24'd110) begin fails++; $display("FAIL overrun_wrptr: got n=%0d want second output 110", qa_val.size()); end
    tests++; if (ovr_a !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b want 1", ovr_a); end
    $display("[TB] overrun: flag=%b outputs=%0d", ovr_a, qa_val.size());
    en_a = 1'b0;
  endtask

  task automatic test_decim_dc();
    int exp;
    do_reset();
    en_b = 1'b1;
    repeat (32) send(4096, 64);
    repeat (10) @(negedge clk);
    tests++; if (qb_val.size() != 16) begin fails++; $display("FAIL decim_count: got %0d want 16", qb_val.size()); end
    for (int m = 0; m < 16 && m < qb_val.size(); m++) begin
      exp = (m < 7) ? (2 * m + 2) * 256 : 4096;
      tests++;
      if (qb_val[m] !== 24'(exp)) begin fails++; $display("FAIL dc_out%0d: got %0d want %0d", m, $signed(qb_val[m]), exp); end
      tests++;
      if (qb_cyc[m] != sa[2*m+1] + 19) begin fails++; $display("FAIL decim_latency%0d: got %0d want 19", m, qb_cyc[m] - sa[2*m+1]); end
      $display("[TB] dc out %0d: d_out=%0d", m, $signed(qb_val[m]));
    end
    tests++; if (ovr_b !== 1'b0) begin fails++; $display("FAIL decim_overrun: got %b want 0", ovr_b); end
    en_b = 1'b0;
  endtask

  task automatic test_rounding();
    do_reset();
    en_b = 1'b1;
    send(4, 64);
    send(4, 64);
    tests++; if (qb_val.size() != 1 || qb_val[0] !== 24'd1) begin fails++; $display("FAIL round_half_pos: got n=%0d want one output of 1", qb_val.size()); end
    do_reset();
    en_b = 1'b1;
    send(-4, 64);
    send(-4, 64);
    tests++; if (qb_val.size() != 1 || qb_val[0] !== 24'd0) begin fails++; $display("FAIL round_half_neg: got n=%0d want one output of 0", qb_val.size()); end
    $display("[TB] rounding: half-LSB cases checked");
    en_b = 1'b0;
  endtask

  task automatic test_reset_mid_mac();
    do_reset();
    en_a = 1'b1;
    @(negedge clk);
    d_in = 31'd777; d_clk = 1'b1;
    repeat (2) @(negedge clk);
    d_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tests++; if ({valid_a, busy_a, ovr_a} !== 3'b000) begin fails++; $display("FAIL midmac_flags: got %b want 000", {valid_a, busy_a, ovr_a}); end
    repeat (30) @(negedge clk);
    tests++; if (qa_val.size() != 0) begin fails++; $display("FAIL midmac_no_valid: got %0d outputs want 0", qa_val.size()); end
    tests++; if (dout_a !== 24'd0) begin fails++; $display("FAIL midmac_dout: got %0d want 0", dout_a); end
    $display("[TB] reset mid-MAC: aborted, rerunning impulse");
    test_impulse();
  endtask

  initial begin
    test_reset();
    test_enable();
    test_impulse();
    test_saturation();
    test_overrun();
    test_decim_dc();
    test_rounding();
    test_reset_mid_mac();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
